uart_packet_assembler: RTL and testbench

- Sits directly downstream of the UART receiver and upstream of the packet processing and count logic.
- Consumes the byte strobe (rx_ready/rx_byte), frames three consecutive bytes into one 24-bit packet and validates the header.
- Splits each packet into address, data and footer fields, held in a one-entry output buffer with a valid/ready handshake.
- Keeps saturating packet and error counters; pkt_count drives the LED display.

---
 rtl/uart_pkt_pkg.sv | 35 +++
 rtl/uart_packet_assembler_byte_gap_timer.sv | 45 ++++
 rtl/uart_packet_assembler.sv | 141 ++++++++++++++
 tb/tb_uart_packet_assembler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkt_pkg
//  Brief    : Shared constants, field layout and FSM states for the
//             UART packet assembler.
//  Revision : 1.0
// ============================================================================
package uart_pkt_pkg;

    localparam logic [2:0] HDR_VALUE = 3'b101;

    localparam int BYTE_W   = 8;
    localparam int HDR_W    = 3;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;
    localparam int FOOTER_W = 3;
    localparam int PKT_W    = 24;
    localparam int BODY_W   = PKT_W - HDR_W;

    localparam int HDR_LSB    = 21;
    localparam int ADDR_LSB   = 11;
    localparam int DATA_LSB   = 3;
    localparam int FOOTER_LSB = 0;

    // Header position inside the first byte on the wire.
    localparam int HDR_BYTE_LSB = HDR_LSB - 2 * BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT0 = 2'd1,
        GOT1 = 2'd2
    } pkt_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_packet_assembler_byte_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_gap_timer
//  Brief    : Inter-byte gap timer; expired pulses on the cycle the gap
//             reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
//  Revision : 1.0
// ============================================================================
module byte_gap_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            logic w_unused_inputs;
            assign w_unused_inputs = clk ^ rst ^ clear ^ enable;
            assign expired         = 1'b0;
        end else begin : g_timeout
            localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

            logic [c_CNT_W-1:0] r_count;

            // The expiring cycle also rewinds the count so a stale value never leaks.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_count <= '0;
                end else if (clear || (enable && (r_count == c_LAST))) begin
                    r_count <= '0;
                end else if (enable) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end

            assign expired = enable && (r_count == c_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_packet_assembler
//  Brief    : Frames three UART bytes into a 24-bit packet, validates the
//             header and buffers addr/data/footer behind valid/ready.
//             Optional footer legality check: PKT_FOOTER_CHECK_EN.
//  Revision : 1.0
// ============================================================================
module uart_packet_assembler
    import uart_pkt_pkg::*;
#(
    parameter logic [2:0] HEADER         = HDR_VALUE,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_ready,
    input  logic [BYTE_W-1:0]   rx_byte,
    output logic                pkt_valid,
    input  logic                pkt_ready,
    output logic [ADDR_W-1:0]   pkt_addr,
    output logic [DATA_W-1:0]   pkt_data,
    output logic [FOOTER_W-1:0] pkt_footer,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [7:0]          err_count,
    output logic                busy
);

    pkt_state_e                    r_state;
    logic [BYTE_W-HDR_W-1:0]       r_addr_hi;
    logic [BYTE_W-1:0]             r_byte1;

    logic                          w_hdr_ok;
    logic                          w_complete;
    logic                          w_footer_ok;
    logic                          w_drain;
    logic                          w_load;
    logic                          w_overflow;
    logic                          w_footer_err;
    logic                          w_hdr_err;
    logic                          w_timeout_err;
    logic                          w_err;
    logic                          w_expired;
    logic                          w_timer_clear;
    logic [BODY_W-1:0]             w_body;

    assign w_hdr_ok   = (rx_byte[HDR_BYTE_LSB +: HDR_W] == HEADER);
    assign w_complete = rx_ready && (r_state == GOT1);
    assign w_body     = {r_addr_hi, r_byte1, rx_byte};

`ifdef PKT_FOOTER_CHECK_EN
    assign w_footer_ok = ~(rx_byte[2] | rx_byte[0]);
`else
    assign w_footer_ok = 1'b1;
`endif

    // A completing packet may refill the buffer in the same cycle it drains.
    assign w_drain       = pkt_valid && pkt_ready;
    assign w_load        = w_complete && w_footer_ok && (!pkt_valid || pkt_ready);
    assign w_overflow    = w_complete && w_footer_ok && pkt_valid && !pkt_ready;
    assign w_footer_err  = w_complete && !w_footer_ok;
    assign w_hdr_err     = rx_ready && (r_state == IDLE) && !w_hdr_ok;
    assign w_timeout_err = w_expired && !rx_ready;
    assign w_err         = w_hdr_err || w_timeout_err || w_overflow || w_footer_err;

    assign w_timer_clear = rx_ready && ((r_state != IDLE) || w_hdr_ok);

    byte_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timer_clear),
        .enable  (r_state != IDLE),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr_hi  <= '0;
            r_byte1    <= '0;
            pkt_valid  <= 1'b0;
            pkt_addr   <= '0;
            pkt_data   <= '0;
            pkt_footer <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            busy       <= 1'b0;
        end else begin
            if (w_load) begin
                pkt_valid  <= 1'b1;
                pkt_addr   <= w_body[ADDR_LSB +: ADDR_W];
                pkt_data   <= w_body[DATA_LSB +: DATA_W];
                pkt_footer <= w_body[FOOTER_LSB +: FOOTER_W];
            end else if (w_drain) begin
                pkt_valid  <= 1'b0;
            end

            if (w_load && (pkt_count != {CNT_W{1'b1}})) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end
            if (w_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            // A byte arriving on the expiry cycle takes priority over the timeout.
            case (r_state)
                IDLE: begin
                    if (rx_ready && w_hdr_ok) begin
                        r_addr_hi <= rx_byte[BYTE_W-HDR_W-1:0];
                        r_state   <= GOT0;
                        busy      <= 1'b1;
                    end
                end
                GOT0: begin
                    if (rx_ready) begin
                        r_byte1 <= rx_byte;
                        r_state <= GOT1;
                    end else if (w_expired) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                GOT1: begin
                    if (rx_ready || w_expired) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_packet_assembler
//  Brief    : Directed self-checking bench for uart_packet_assembler.
//  Revision : 1.0
// ============================================================================
module tb_uart_packet_assembler;

    logic        clk;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_byte;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [9:0]  pkt_addr;
    logic [7:0]  pkt_data;
    logic [2:0]  pkt_footer;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;
    logic        busy;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [20:0] cap_q[$];

    uart_packet_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .rx_ready   (rx_ready),
        .rx_byte    (rx_byte),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_addr   (pkt_addr),
        .pkt_data   (pkt_data),
        .pkt_footer (pkt_footer),
        .pkt_count  (pkt_count),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && pkt_valid && pkt_ready) begin
            cap_q.push_back({pkt_addr, pkt_data, pkt_footer});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        cap_q.delete();
    endtask

    task automatic check_entry(input string tag, input int idx, input logic [20:0] exp);
        logic [20:0] obs;
        obs = (idx < cap_q.size()) ? cap_q[idx] : 21'h1FFFFF;
        check(tag, 32'(obs), 32'(exp));
    endtask

    initial begin
        int k;
        rst       = 1'b0;
        rx_ready  = 1'b0;
        rx_byte   = 8'h00;
        pkt_ready = 1'b1;
        idle(3);
        check("reset_valid", 32'(pkt_valid), 32'd0);
        check("reset_busy",  32'(busy),      32'd0);
        check("reset_pcnt",  32'(pkt_count), 32'd0);
        check("reset_ecnt",  32'(err_count), 32'd0);
        check("reset_addr",  32'(pkt_addr),  32'd0);
        rst = 1'b1;

        // Single packet, 20 clocks between bytes.
        send_byte(8'hA0);
        idle(20);
        send_byte(8'h08);
        idle(20);
        send_byte(8'h02);
        check("single_latency_valid", 32'(pkt_valid), 32'd1);
        idle(1);
        check("single_valid_falls", 32'(pkt_valid), 32'd0);
        idle(2);
        check("single_qsize", 32'(cap_q.size()), 32'd1);
        check_entry("single_fields", 0, {10'd1, 8'h00, 3'b010});
        check("single_pcnt", 32'(pkt_count), 32'd1);
        check("single_ecnt", 32'(err_count), 32'd0);

        // Ten packets, addresses 0..9.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_byte(8'hA0);
            send_byte(8'(i << 3));
            send_byte((i % 2 == 1) ? 8'h02 : 8'h00);
        end
        idle(3);
        check("ten_qsize", 32'(cap_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check_entry("ten_fields", i, {10'(i), 8'h00, ((i % 2 == 1) ? 3'b010 : 3'b000)});
        end
        check("ten_pcnt", 32'(pkt_count), 32'h000A);
        check("ten_ecnt", 32'(err_count), 32'd0);

        // Bad header resynchronisation.
        do_reset();
        send_byte(8'h40);
        check("hdr_err_ecnt", 32'(err_count), 32'd1);
        check("hdr_err_busy", 32'(busy),      32'd0);
        send_byte(8'hA0);
        send_byte(8'h10);
        send_byte(8'h02);
        idle(2);
        check_entry("hdr_resync_fields", 0, {10'd2, 8'h00, 3'b010});
        check("hdr_resync_pcnt", 32'(pkt_count), 32'd1);
        check("hdr_resync_ecnt", 32'(err_count), 32'd1);

        // Inter-byte timeout.
        do_reset();
        send_byte(8'hA0);
        send_byte(8'h08);
        k = 0;
        while (busy && k < 5000) begin
            idle(1);
            k++;
        end
        check("timeout_cycle", 32'(k), 32'd4096);
        check("timeout_ecnt", 32'(err_count), 32'd1);
        idle(5000 - k);
        send_byte(8'hA0);
        send_byte(8'h18);
        send_byte(8'h00);
        idle(2);
        check("timeout_qsize", 32'(cap_q.size()), 32'd1);
        check_entry("timeout_next_fields", 0, {10'd3, 8'h00, 3'b000});
        check("timeout_ecnt_after", 32'(err_count), 32'd1);

        // Overflow with a stalled consumer.
        do_reset();
        pkt_ready = 1'b0;
        send_byte(8'hA0);
        send_byte(8'h08);
        send_byte(8'h02);
        send_byte(8'hA0);
        send_byte(8'h10);
        send_byte(8'h02);
        idle(2);
        check("ovf_valid", 32'(pkt_valid), 32'd1);
        check("ovf_addr",  32'(pkt_addr),  32'd1);
        check("ovf_footer", 32'(pkt_footer), 32'b010);
        check("ovf_ecnt",  32'(err_count), 32'd1);
        check("ovf_pcnt",  32'(pkt_count), 32'd1);
        check("ovf_no_xfer", 32'(cap_q.size()), 32'd0);
        pkt_ready = 1'b1;
        idle(1);
        check("ovf_drain_valid", 32'(pkt_valid), 32'd0);
        idle(2);
        check("ovf_drain_qsize", 32'(cap_q.size()), 32'd1);
        check_entry("ovf_drain_fields", 0, {10'd1, 8'h00, 3'b010});

        // Completion coinciding with a handshake refills the buffer.
        do_reset();
        pkt_ready = 1'b0;
        send_byte(8'hA0);
        send_byte(8'h08);
        send_byte(8'h02);
        send_byte(8'hA0);
        send_byte(8'h10);
        @(posedge clk);
        #1;
        rx_ready  = 1'b1;
        rx_byte   = 8'h00;
        pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready  = 1'b0;
        pkt_ready = 1'b0;
        check("same_cycle_valid", 32'(pkt_valid), 32'd1);
        check("same_cycle_addr",  32'(pkt_addr),  32'd2);
        check("same_cycle_footer", 32'(pkt_footer), 32'b000);
        check("same_cycle_pcnt",  32'(pkt_count), 32'd2);
        check("same_cycle_ecnt",  32'(err_count), 32'd0);
        check_entry("same_cycle_first", 0, {10'd1, 8'h00, 3'b010});

        // Asynchronous reset mid-packet with a buffered packet.
        do_reset();
        pkt_ready = 1'b0;
        send_byte(8'hA0);
        send_byte(8'h08);
        send_byte(8'h02);
        send_byte(8'hA0);
        send_byte(8'h10);
        #3;
        rst = 1'b0;
        #1;
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_valid", 32'(pkt_valid), 32'd0);
        check("arst_pcnt",  32'(pkt_count), 32'd0);
        check("arst_ecnt",  32'(err_count), 32'd0);
        idle(1);
        rst = 1'b1;
        cap_q.delete();
        pkt_ready = 1'b1;
        send_byte(8'hA0);
        send_byte(8'h18);
        send_byte(8'h00);
        idle(2);
        check_entry("arst_next_fields", 0, {10'd3, 8'h00, 3'b000});
        check("arst_next_pcnt", 32'(pkt_count), 32'd1);

`ifdef PKT_FOOTER_CHECK_EN
        do_reset();
        send_byte(8'hA0);
        send_byte(8'h08);
        send_byte(8'h05);
        idle(2);
        check("footer_err_ecnt",  32'(err_count), 32'd1);
        check("footer_err_pcnt",  32'(pkt_count), 32'd0);
        check("footer_err_qsize", 32'(cap_q.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
